// File: rtl/victim_evict_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : victim_evict_initiator_pkg
// Purpose : Shared types for the victim-cache eviction initiator.
// Revision: 1.0
// ============================================================================
package victim_evict_initiator_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] cache_line;
    typedef logic [11:0]  victim_tag;

    typedef struct packed {
        victim_tag tag;
        cache_line line;
    } evict_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } evict_state_t;

    function automatic victim_tag tag_of(input lc3b_word addr);
        return addr[15:4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/victim_evict_initiator_evict_fifo.sv
`default_nettype none
// ============================================================================
// Module  : evict_fifo
// Purpose : Eviction line buffer with head access and youngest-entry tag lookup.
// Revision: 1.0
// ============================================================================
module evict_fifo
    import victim_evict_initiator_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  evict_entry_t push_entry_i,
    input  logic         pop_i,
    input  victim_tag    lookup_tag_i,
    output logic         full_o,
    output logic         empty_o,
    output evict_entry_t head_o,
    output logic         match_o,
    output cache_line    match_line_o
);

    localparam int c_ptr_w = $clog2(DEPTH);

    evict_entry_t         mem_q [DEPTH];
    logic [c_ptr_w-1:0]   wr_ptr_q;
    logic [c_ptr_w-1:0]   rd_ptr_q;
    logic [c_ptr_w:0]     count_q;
    logic                 w_push;
    logic                 w_pop;
    logic [c_ptr_w-1:0]   w_idx;

    assign full_o  = (int'(count_q) == DEPTH);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Full is judged before any same-cycle pop, so a push never races the head.
    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Walk oldest to youngest so the last hit (youngest) wins.
    always_comb begin
        match_o      = 1'b0;
        match_line_o = '0;
        w_idx        = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = rd_ptr_q + c_ptr_w'(i);
            if ((i < int'(count_q)) && (mem_q[w_idx].tag == lookup_tag_i)) begin
                match_o      = 1'b1;
                match_line_o = mem_q[w_idx].line;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/victim_evict_initiator.sv
`default_nettype none
// ============================================================================
// Module  : victim_evict_initiator
// Purpose : Drains evicted L1 lines to the victim cache and passes L1 misses
//           through; define VICTIM_EVICT_FWD_EN to answer buffered hits locally.
// Revision: 1.0
// ============================================================================
module victim_evict_initiator
    import victim_evict_initiator_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         evict_valid,
    input  logic [15:0]  evict_address,
    input  logic [127:0] evict_line,
    output logic         evict_ready,
    input  logic         l1_read,
    input  logic [15:0]  l1_address,
    output logic [127:0] l1_rdata,
    output logic         l1_resp,
    output logic [15:0]  mem_address,
    output logic [127:0] mem_wdata,
    output logic         mem_read,
    output logic         mem_write,
    input  logic [127:0] mem_rdata,
    input  logic         mem_resp
);

    evict_state_t  state_q, state_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    lc3b_word      mem_address_q, mem_address_d;
    cache_line     mem_wdata_q, mem_wdata_d;
    logic          l1_resp_q, l1_resp_d;
    cache_line     l1_rdata_q, l1_rdata_d;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    evict_entry_t  w_push_entry;
    evict_entry_t  w_head;
    logic          w_match;
    cache_line     w_match_line;
    logic          w_read_req;
    logic          w_fwd_hit;
    logic          w_pass_read;

    assign evict_ready  = !w_full;
    assign w_push       = evict_valid && evict_ready;
    assign w_pop        = (state_q == WRITE) && mem_resp;
    assign w_push_entry = '{tag: tag_of(evict_address), line: evict_line};

    evict_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (w_push),
        .push_entry_i (w_push_entry),
        .pop_i        (w_pop),
        .lookup_tag_i (tag_of(l1_address)),
        .full_o       (w_full),
        .empty_o      (w_empty),
        .head_o       (w_head),
        .match_o      (w_match),
        .match_line_o (w_match_line)
    );

    // The request answered last cycle is still asserted; ignore it for one cycle.
    assign w_read_req  = l1_read && !l1_resp_q;
    assign w_pass_read = w_read_req && !w_match;

`ifdef VICTIM_EVICT_FWD_EN
    assign w_fwd_hit = w_read_req && w_match;
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^evict_address[3:0];
`else
    // Without forwarding a matching read drains the FIFO until the match clears.
    assign w_fwd_hit = 1'b0;
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{evict_address[3:0], w_match_line};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            l1_resp_q     <= 1'b0;
            l1_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            l1_resp_q     <= l1_resp_d;
            l1_rdata_q    <= l1_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!l1_resp_q) begin
                    if (w_fwd_hit) begin
                        state_d = IDLE;
                    end else if (w_pass_read) begin
                        state_d = READ;
                    end else if (!w_empty) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE:   if (mem_resp) state_d = IDLE;
            READ:    if (mem_resp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        l1_resp_d     = 1'b0;
        l1_rdata_d    = l1_rdata_q;
        case (state_q)
            IDLE: begin
                if (!l1_resp_q) begin
                    if (w_fwd_hit) begin
                        l1_resp_d  = 1'b1;
                        l1_rdata_d = w_match_line;
                    end else if (w_pass_read) begin
                        mem_read_d    = 1'b1;
                        mem_address_d = l1_address;
                    end else if (!w_empty) begin
                        mem_write_d   = 1'b1;
                        mem_address_d = {w_head.tag, 4'h0};
                        mem_wdata_d   = w_head.line;
                    end
                end
            end
            WRITE: begin
                if (mem_resp) begin
                    mem_write_d = 1'b0;
                end
            end
            READ: begin
                if (mem_resp) begin
                    mem_read_d = 1'b0;
                    l1_resp_d  = 1'b1;
                    l1_rdata_d = mem_rdata;
                end
            end
            default: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign l1_resp     = l1_resp_q;
    assign l1_rdata    = l1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_victim_evict_initiator.sv
`default_nettype none
// ============================================================================
// Module  : tb_victim_evict_initiator
// Purpose : Scoreboard bench for victim_evict_initiator with a victim-cache model.
// Revision: 1.0
// ============================================================================
module tb_victim_evict_initiator;

    localparam int EV_WR = 0;
    localparam int EV_RD = 1;
    localparam int EV_L1 = 2;

    localparam logic [127:0] LA = {4{32'hA000_000A}};
    localparam logic [127:0] LB = {4{32'hB111_111B}};
    localparam logic [127:0] LC = {4{32'hC222_222C}};
    localparam logic [127:0] LD = {4{32'hD333_333D}};
    localparam logic [127:0] LE = {4{32'hE444_444E}};

    logic         clk = 1'b0;
    logic         reset;
    logic         evict_valid;
    logic [15:0]  evict_address;
    logic [127:0] evict_line;
    logic         evict_ready;
    logic         l1_read;
    logic [15:0]  l1_address;
    logic [127:0] l1_rdata;
    logic         l1_resp;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_read;
    logic         mem_write;
    logic [127:0] mem_rdata = '0;
    logic         mem_resp = 1'b0;

    typedef struct {
        int           kind;
        logic [15:0]  addr;
        logic [127:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_resp_cyc = -10;
    int  lat = 2;
    bit  hold = 1'b0;
    int  wait_cnt = 0;
    bit  prev_w = 1'b0;
    bit  prev_r = 1'b0;

    victim_evict_initiator #(.DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .evict_valid   (evict_valid),
        .evict_address (evict_address),
        .evict_line    (evict_line),
        .evict_ready   (evict_ready),
        .l1_read       (l1_read),
        .l1_address    (l1_address),
        .l1_rdata      (l1_rdata),
        .l1_resp       (l1_resp),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_rdata     (mem_rdata),
        .mem_resp      (mem_resp)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [127:0] rd_pat(input logic [15:0] a);
        return {8{a ^ 16'hA5A5}};
    endfunction

    // Victim cache: answers lat cycles after a request appears unless held off.
    initial forever begin
        @(negedge clk);
        mem_resp = 1'b0;
        if ((mem_read || mem_write) && !hold && !reset) begin
            if (wait_cnt >= lat - 1) begin
                mem_resp      = 1'b1;
                mem_rdata     = rd_pat(mem_address);
                wait_cnt      = 0;
                last_resp_cyc = cyc;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic observe(input int kind, input logic [15:0] a, input logic [127:0] d);
        ev_t e;
        bit  ok;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, required no event", kind, a, d);
        end else begin
            e  = exp_q.pop_front();
            ok = (e.kind == kind);
            if (kind != EV_L1 && a !== e.addr) ok = 1'b0;
            if (kind != EV_RD && d !== e.data) ok = 1'b0;
            if (!ok) begin
                errors++;
                $display("FAIL event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (mem_write && !prev_w) observe(EV_WR, mem_address, mem_wdata);
        if (mem_read && !prev_r)  observe(EV_RD, mem_address, '0);
        if (l1_resp)              observe(EV_L1, 16'h0, l1_rdata);
        prev_w = mem_write;
        prev_r = mem_read;
    end

    task automatic expect_ev(input int kind, input logic [15:0] a, input logic [127:0] d);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [127:0] l,
                        output int tries, output int acc_cyc);
        bit acc;
        evict_valid   = 1'b1;
        evict_address = a;
        evict_line    = l;
        tries         = 0;
        acc_cyc       = -1;
        acc           = 1'b0;
        while (!acc && tries < 300) begin
            acc = evict_ready;
            @(negedge clk);
            tries++;
        end
        if (acc) begin
            acc_cyc = cyc;
        end else begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got no accept for %h, required accept", a);
        end
        evict_valid = 1'b0;
    endtask

    task automatic l1_req(input logic [15:0] a, output int resp_cyc);
        int n;
        n          = 0;
        l1_read    = 1'b1;
        l1_address = a;
        resp_cyc   = -1;
        while (resp_cyc < 0 && n < 400) begin
            @(negedge clk);
            n++;
            if (l1_resp) resp_cyc = cyc;
        end
        if (resp_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL l1_timeout: got no l1_resp for %h, required l1_resp", a);
        end
        l1_read = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got %0d events outstanding, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int t0, t1, ac, rc, first_resp;
        reset         = 1'b1;
        evict_valid   = 1'b0;
        evict_address = '0;
        evict_line    = '0;
        l1_read       = 1'b0;
        l1_address    = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_read", {127'b0, mem_read}, 128'd0);
        chk("rst_mem_write", {127'b0, mem_write}, 128'd0);
        chk("rst_l1_resp", {127'b0, l1_resp}, 128'd0);
        chk("rst_mem_address", {112'b0, mem_address}, 128'd0);
        chk("rst_mem_wdata", mem_wdata, 128'd0);
        chk("rst_evict_ready", {127'b0, evict_ready}, 128'd1);
        reset = 1'b0;
        @(negedge clk);

        // Two evictions drain in order without back-pressure.
        expect_ev(EV_WR, 16'h1230, LA);
        expect_ev(EV_WR, 16'h4560, LB);
        push(16'h1230, LA, t0, ac);
        push(16'h4560, LB, t1, ac);
        chk_int("t1_ready_first", t0, 1);
        chk_int("t1_ready_second", t1, 1);
        drain("t1");

        // Full FIFO: third push lands the cycle after the first completion.
        hold = 1'b1;
        expect_ev(EV_WR, 16'h5550, LA);
        expect_ev(EV_WR, 16'h6660, LB);
        expect_ev(EV_WR, 16'h8880, LC);
        push(16'h5550, LA, t0, ac);
        push(16'h6660, LB, t1, ac);
        chk("t2_ready_full", {127'b0, evict_ready}, 128'd0);
        fork
            push(16'h8880, LC, t0, ac);
            begin
                repeat (3) @(negedge clk);
                hold = 1'b0;
            end
        join
        first_resp = last_resp_cyc;
        chk_int("t2_third_push_cycle", ac - first_resp, 2);
        drain("t2");

        // Read hitting a buffered line.
`ifdef VICTIM_EVICT_FWD_EN
        expect_ev(EV_L1, 16'h0, LA);
        expect_ev(EV_WR, 16'h1230, LA);
`else
        expect_ev(EV_WR, 16'h1230, LA);
        expect_ev(EV_RD, 16'h1236, '0);
        expect_ev(EV_L1, 16'h0, rd_pat(16'h1236));
`endif
        push(16'h1230, LA, t0, ac);
        l1_req(16'h1236, rc);
        drain("t3");

        // Two buffered copies of one line; the youngest must be seen.
        hold = 1'b1;
        expect_ev(EV_RD, 16'h7770, '0);
        expect_ev(EV_L1, 16'h0, rd_pat(16'h7770));
`ifdef VICTIM_EVICT_FWD_EN
        expect_ev(EV_L1, 16'h0, LC);
        expect_ev(EV_WR, 16'h1230, LA);
        expect_ev(EV_WR, 16'h1230, LC);
`else
        expect_ev(EV_WR, 16'h1230, LA);
        expect_ev(EV_WR, 16'h1230, LC);
        expect_ev(EV_RD, 16'h1230, '0);
        expect_ev(EV_L1, 16'h0, rd_pat(16'h1230));
`endif
        fork
            l1_req(16'h7770, rc);
            begin
                push(16'h1230, LA, t0, ac);
                push(16'h1230, LC, t1, ac);
                hold = 1'b0;
            end
        join
        l1_req(16'h1230, rc);
        drain("t4");

        // Miss read takes priority over a non-empty FIFO.
        lat = 3;
        expect_ev(EV_RD, 16'h7770, '0);
        expect_ev(EV_L1, 16'h0, rd_pat(16'h7770));
        expect_ev(EV_WR, 16'h2220, LD);
        push(16'h2220, LD, t0, ac);
        l1_req(16'h7770, rc);
        chk_int("t5_l1_resp_latency", rc - last_resp_cyc, 1);
        drain("t5");
        lat = 2;

        // Reset while a write is outstanding abandons it.
        hold = 1'b1;
        expect_ev(EV_WR, 16'h3330, LE);
        push(16'h3330, LE, t0, ac);
        t1 = 0;
        while (!mem_write && t1 < 20) begin
            @(negedge clk);
            t1++;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("t6_mem_write", {127'b0, mem_write}, 128'd0);
        chk("t6_mem_read", {127'b0, mem_read}, 128'd0);
        chk("t6_evict_ready", {127'b0, evict_ready}, 128'd1);
        chk("t6_mem_address", {112'b0, mem_address}, 128'd0);
        reset = 1'b0;
        hold  = 1'b0;
        repeat (12) @(negedge clk);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
